// File: rtl/avalon_body_regs.sv
// Avalon-MM register file for per-body radius/x/y/z with a shadow bank that is
// copied atomically into the active bank on a synchronised VS edge or on software command.
module avalon_body_regs #(
  parameter int NUM_BODIES = 2,
  parameter int ADDR_W     = 5
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      AVL_CS,
  input  logic                      AVL_READ,
  input  logic                      AVL_WRITE,
  input  logic [3:0]                AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]         AVL_ADDR,
  input  logic [31:0]               AVL_WRITEDATA,
  output logic [31:0]               AVL_READDATA,
  output logic                      AVL_READDATAVALID,
  input  logic                      VS_IN,
  output logic [128*NUM_BODIES-1:0] ACTIVE_REGS,
  output logic [15:0]               FRAME_COUNT,
  output logic                      FRAME_IRQ
);

  localparam int NUM_REGS = 4 * NUM_BODIES;
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_REGS + 1);

  generate
    if (NUM_REGS + 2 > 2 ** ADDR_W) begin : g_addr_check
      $error("avalon_body_regs: ADDR_W too small for NUM_BODIES");
    end
  endgenerate

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0] shadow_r [NUM_REGS];
  logic [31:0] active_r [NUM_REGS];
  logic        arm_r, irq_en_r, commit_now_r, commit_done_r;
  logic        vs_s1_r, vs_s2_r, vs_s3_r;
  logic        frame_irq_r, rdvalid_r;
  logic [15:0] frame_count_r;
  logic [31:0] rdata_r;

  logic        wr_s, rd_s, ctrl_wr_s, status_rd_s, edge_s, commit_s;
  logic [31:0] rdata_s;

  assign wr_s        = AVL_CS & AVL_WRITE;
  assign rd_s        = AVL_CS & AVL_READ;
  assign ctrl_wr_s   = wr_s & (AVL_ADDR == CTRL_ADDR);
  assign status_rd_s = rd_s & (AVL_ADDR == STATUS_ADDR);
  assign edge_s      = vs_s2_r & ~vs_s3_r;
  // The edge only commits against the ARM value held before any same-cycle CTRL write.
  assign commit_s    = (edge_s & arm_r) | commit_now_r;

  // Read mux: shadow words, CTRL, STATUS, zero elsewhere.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (AVL_ADDR == CTRL_ADDR) begin
      rdata_s = {29'h0, irq_en_r, 1'b0, arm_r};
    end else if (AVL_ADDR == STATUS_ADDR) begin
      rdata_s = {frame_count_r, 14'h0, arm_r, commit_done_r};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (AVL_ADDR == ADDR_W'(i)) begin
          rdata_s = shadow_r[i];
        end else begin
          rdata_s = rdata_s;
        end
      end
    end
  end

  // Three-flop VS synchroniser.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_s1_r <= 1'b0;
      vs_s2_r <= 1'b0;
      vs_s3_r <= 1'b0;
    end else begin
      vs_s1_r <= VS_IN;
      vs_s2_r <= vs_s1_r;
      vs_s3_r <= vs_s2_r;
    end
  end

  // Shadow bank takes byte-lane writes; active bank copies the pre-write shadow on commit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= 32'h0000_0000;
        active_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_s && (AVL_ADDR == ADDR_W'(i))) begin
          shadow_r[i] <= byte_merge(shadow_r[i], AVL_WRITEDATA, AVL_BYTE_EN);
        end
        if (commit_s) begin
          active_r[i] <= shadow_r[i];
        end
      end
    end
  end

  // Control, frame counter, commit_done and interrupt.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      arm_r         <= 1'b0;
      irq_en_r      <= 1'b0;
      commit_now_r  <= 1'b0;
      commit_done_r <= 1'b0;
      frame_count_r <= 16'h0000;
      frame_irq_r   <= 1'b0;
    end else begin
      commit_now_r <= ctrl_wr_s & AVL_BYTE_EN[0] & AVL_WRITEDATA[1];
      if (ctrl_wr_s && AVL_BYTE_EN[0]) begin
        arm_r    <= AVL_WRITEDATA[0];
        irq_en_r <= AVL_WRITEDATA[2];
      end else if (commit_s) begin
        arm_r <= 1'b0;
      end
      if (commit_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
      if (commit_s) begin
        commit_done_r <= 1'b1;
      end else if (status_rd_s) begin
        commit_done_r <= 1'b0;
      end
      frame_irq_r <= commit_done_r & irq_en_r;
    end
  end

  // Fixed one-cycle read response.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_r   <= 32'h0000_0000;
      rdvalid_r <= 1'b0;
    end else begin
      rdvalid_r <= rd_s;
      if (rd_s) begin
        rdata_r <= rdata_s;
      end
    end
  end

  generate
    for (genvar j = 0; j < NUM_REGS; j++) begin : g_active
      assign ACTIVE_REGS[32*j +: 32] = active_r[j];
    end
  endgenerate

  assign AVL_READDATA      = rdata_r;
  assign AVL_READDATAVALID = rdvalid_r;
  assign FRAME_COUNT       = frame_count_r;
  assign FRAME_IRQ         = frame_irq_r;

endmodule

// File: tb/tb_avalon_body_regs.sv
// Scoreboard bench for avalon_body_regs: a transaction-level model predicts read data,
// active bank, frame count and interrupt; a monitor checks read responses as they appear.
module tb_avalon_body_regs;

  localparam int NR = 8;

  logic         CLK = 1'b0;
  logic         RESET, AVL_CS, AVL_READ, AVL_WRITE, VS_IN;
  logic [3:0]   AVL_BYTE_EN;
  logic [4:0]   AVL_ADDR;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA;
  logic         AVL_READDATAVALID, FRAME_IRQ;
  logic [255:0] ACTIVE_REGS;
  logic [15:0]  FRAME_COUNT;

  avalon_body_regs #(.NUM_BODIES(2), .ADDR_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AVL_READDATAVALID(AVL_READDATAVALID), .VS_IN(VS_IN),
    .ACTIVE_REGS(ACTIVE_REGS), .FRAME_COUNT(FRAME_COUNT), .FRAME_IRQ(FRAME_IRQ)
  );

  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model state
  logic [31:0] sh_m [NR];
  logic [31:0] ac_m [NR];
  logic        arm_m, irq_en_m, done_m, pend_m, irq_m;
  logic [15:0] count_m;

  typedef struct { logic [31:0] data; int cyc; } rd_exp_t;
  rd_exp_t q[$];
  rd_exp_t mon_e;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a < NR) return sh_m[a];
    if (a == NR) return {29'h0, irq_en_m, 1'b0, arm_m};
    if (a == NR + 1) return {count_m, 14'h0, arm_m, done_m};
    return 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction

  // One bus cycle: drive, advance the model, wait for the next falling edge.
  task automatic drive(input logic cs, input logic rd, input logic wr, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic vs_edge);
    logic commit, irq_next;
    AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr;
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    if (cs && rd) q.push_back('{model_rd(a), cyc + 1});
    irq_next = done_m & irq_en_m;
    commit = pend_m | (vs_edge & arm_m);
    pend_m = 1'b0;
    if (commit) begin
      for (int j = 0; j < NR; j++) ac_m[j] = sh_m[j];
      arm_m = 1'b0;
      count_m = count_m + 16'd1;
      done_m = 1'b1;
    end
    if (cs && wr) begin
      if (a < NR) sh_m[a] = merge(sh_m[a], d, be);
      else if (a == NR && be[0]) begin
        arm_m = d[0]; pend_m = d[1]; irq_en_m = d[2];
      end
    end
    if (cs && rd && a == NR + 1 && !commit) done_m = 1'b0;
    irq_m = irq_next;
    @(negedge CLK);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b1, 1'b0, 1'b1, a, d, be, 1'b0);
  endtask

  task automatic rd(input logic [4:0] a);
    drive(1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic idle(input int n, input logic vs_edge);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, vs_edge);
  endtask

  task automatic check_state(input string tag);
    logic [255:0] exp_v;
    for (int j = 0; j < NR; j++) exp_v[32*j +: 32] = ac_m[j];
    chk({tag, "_active"}, ACTIVE_REGS, exp_v);
    chk({tag, "_frame_count"}, 256'(FRAME_COUNT), 256'(count_m));
    chk({tag, "_frame_irq"}, 256'(FRAME_IRQ), 256'(irq_m));
  endtask

  // VS rising edge: the commit must land on the third clock edge after VS_IN rises.
  task automatic vs_rise(input string tag);
    VS_IN = 1'b1;
    idle(2, 1'b0);
    check_state({tag, "_pre"});
    idle(1, 1'b1);
    check_state({tag, "_post"});
  endtask

  task automatic vs_fall();
    VS_IN = 1'b0;
    idle(3, 1'b0);
  endtask

  // Monitor: every read-valid pulse must match the oldest outstanding read.
  always @(negedge CLK) begin
    if (AVL_READDATAVALID) begin
      if (q.size() == 0) begin
        chk("rd_unexpected", 256'(AVL_READDATAVALID), 256'(1'b0));
      end else begin
        mon_e = q.pop_front();
        chk("rd_data", 256'(AVL_READDATA), 256'(mon_e.data));
        chk("rd_latency", 256'(cyc), 256'(mon_e.cyc));
      end
    end
  end

  initial begin
    int k;
    int r;
    RESET = 1'b1; VS_IN = 1'b0;
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_ADDR = 5'd0; AVL_WRITEDATA = 32'h0; AVL_BYTE_EN = 4'h0;
    for (int j = 0; j < NR; j++) begin sh_m[j] = 32'h0; ac_m[j] = 32'h0; end
    arm_m = 1'b0; irq_en_m = 1'b0; done_m = 1'b0; pend_m = 1'b0; irq_m = 1'b0;
    count_m = 16'h0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    check_state("reset");
    for (int a = 0; a < NR + 2; a++) rd(5'(a));
    idle(2, 1'b0);

    wr(5'd1, 32'h0000_0140, 4'hF);
    rd(5'd1);
    idle(1, 1'b0);
    check_state("no_commit");

    wr(5'd5, 32'hAABB_CCDD, 4'hF);
    wr(5'd5, 32'h1122_3344, 4'h5);
    rd(5'd5);
    idle(1, 1'b0);

    wr(5'd8, 32'h0000_0005, 4'h1);
    idle(1, 1'b0);
    vs_rise("vs_commit");
    idle(1, 1'b0);
    check_state("irq");
    rd(5'd9);
    rd(5'd9);
    idle(2, 1'b0);
    check_state("irq_clear");
    vs_fall();

    for (int t = 0; t < 5; t++) begin
      vs_rise("unarmed");
      vs_fall();
    end
    wr(5'd8, 32'h0000_0002, 4'h1);
    idle(1, 1'b0);
    check_state("commit_now");

    wr(5'd8, 32'h0000_0002, 4'h1);
    wr(5'd2, 32'hDEAD_BEEF, 4'hF);
    idle(1, 1'b0);
    check_state("commit_vs_write");
    rd(5'd2);
    idle(1, 1'b0);

    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: wr(5'($urandom_range(0, 11)), $urandom, 4'($urandom_range(0, 15)));
        3, 4:    rd(5'($urandom_range(0, 11)));
        5:       wr(5'd8, 32'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        6:       rd(5'd9);
        7:       drive(1'b1, 1'b1, 1'b1, 5'($urandom_range(0, 9)), $urandom, 4'hF, 1'b0);
        default: idle(1, 1'b0);
      endcase
      if (t % 50 == 49) check_state("random");
    end
    idle(2, 1'b0);
    check_state("random_end");

    k = 16'hFFFF - count_m;
    for (int t = 0; t < k; t++) wr(5'd8, 32'h0000_0002, 4'h1);
    idle(1, 1'b0);
    check_state("count_ffff");
    wr(5'd8, 32'h0000_0002, 4'h1);
    idle(1, 1'b0);
    check_state("count_wrap");

    idle(3, 1'b0);
    chk("rd_outstanding", 256'(q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_body_regs.md
Name: avalon_body_regs

Overview:
Parametrised Avalon-MM slave register file holding radius/x/y/z for NUM_BODIES rendered bodies.
CPU writes land in a shadow bank. The shadow bank is copied atomically into an active bank on a frame boundary (synchronised VS_IN rising edge) or on software command, so the ball renderers never see a half-updated frame.
Sits between the Nios II Avalon fabric and the per-body renderer instances.
Also provides frame counting, status readback and a frame interrupt.

Parameters:
NUM_BODIES, 2, number of bodies; 4 x 32-bit registers each
ADDR_W, 5, Avalon word-address width; must satisfy 4*NUM_BODIES+2 <= 2**ADDR_W (elaboration error otherwise)

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  synchronous, active-high
AVL_CS  in  1  chip select
AVL_READ  in  1  read strobe
AVL_WRITE  in  1  write strobe
AVL_BYTE_EN  in  4  byte enables
AVL_ADDR  in  ADDR_W  word address
AVL_WRITEDATA  in  32  write data
AVL_READDATA  out  32  read data, registered
AVL_READDATAVALID  out  1  read data valid
VS_IN  in  1  VGA vertical sync, asynchronous to CLK
ACTIVE_REGS  out  128*NUM_BODIES  active bank; body b at [128b+127:128b], ordered {z,y,x,radius} MSB->LSB
FRAME_COUNT  out  16  commits performed, wraps
FRAME_IRQ  out  1  level interrupt

Behaviour:
- Reset: shadow bank, active bank, CTRL, commit_done, FRAME_COUNT, sync flops = 0; AVL_READDATA=0, AVL_READDATAVALID=0, FRAME_IRQ=0. Mid-operation reset discards pending arm and any in-flight read.
- Map (word addresses):
  - 4b+0..3 = body b radius, x, y, z (shadow)
  - 4N = CTRL: bit0 ARM, bit1 COMMIT_NOW, bit2 IRQ_EN
  - 4N+1 = STATUS (read-only): [31:16] FRAME_COUNT, [1] ARM, [0] commit_done
  - Other addresses: reads return 0; writes ignored.
- Writes (AVL_CS & AVL_WRITE): each byte lane i updates independently when AVL_BYTE_EN[i]=1, in any pattern including 0000 (no-op).
  - CTRL bit1 is not stored; it requests one immediate commit on the next cycle.
  - Writes to STATUS are ignored.
- Reads (AVL_CS & AVL_READ): fixed latency 1. AVL_READDATA and AVL_READDATAVALID are valid the cycle after the request; READDATAVALID is a single-cycle pulse per read.
  - Shadow addresses return shadow contents, not active.
  - Reading STATUS clears commit_done after returning its value. If a commit sets it in the same cycle, set wins.
  - Simultaneous read and write to the same address: read returns the pre-write value.
- VS sync: VS_IN -> s1 -> s2 -> s3. Edge = s2 & ~s3. ACTIVE_REGS changes on the 3rd CLK edge, counting the first edge that samples VS_IN=1.
- Commit condition: (edge & ARM) | pending COMMIT_NOW. A commit in one cycle:
  - active <= shadow for all bodies;
  - ARM <= 0;
  - FRAME_COUNT <= FRAME_COUNT+1 (0xFFFF wraps to 0);
  - commit_done <= 1.
- Edge with ARM=0: no commit, no count.
- Simultaneous events:
  - CTRL write setting ARM in the edge cycle: the edge uses the old ARM (0), so no commit; ARM becomes 1.
  - Shadow write in the commit cycle: the commit copies the pre-write value; the write lands in shadow only.
  - COMMIT_NOW and edge in the same cycle: exactly one commit, count +1.
  - CTRL write with ARM=1 in the same cycle a commit clears ARM: the write wins (ARM=1).
- FRAME_IRQ = commit_done & IRQ_EN, registered; asserts the cycle after commit_done sets.

Test Plan:
- Reset, then read every mapped address -> all 0; each READDATAVALID one pulse, exactly 1 cycle after its read.
- Write 0x00000140 to addr 1, read addr 1 -> 0x00000140; ACTIVE_REGS[63:32] stays 0 with no commit.
- Write 0xAABBCCDD to addr 5 (BYTE_EN 1111), then 0x11223344 with BYTE_EN 0101 -> readback 0xAA22CC44.
- ARM=1, IRQ_EN=1, raise VS_IN -> ACTIVE_REGS updates on the 3rd CLK edge; FRAME_COUNT=1; FRAME_IRQ=1; STATUS read returns 0x00010001; second STATUS read returns 0x00010000.
- ARM=0, toggle VS_IN 5 times -> FRAME_COUNT unchanged, active bank unchanged. Then write CTRL=0x2 -> commit next cycle, FRAME_COUNT +1.
- Shadow write to addr 2 in the same cycle as the commit -> active y gets the old value, shadow gets the new value. Force FRAME_COUNT to 0xFFFF, then commit -> 0x0000.
